// File: rtl/port_master_pkg.sv
// Shared constants for the port-mapped arithmetic master and its bus monitor.
// Holds the default data width, the peripheral port codes and the FSM state
// encoding so that RTL and verification agree on one set of numbers.
package port_master_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int PORT_WIDTH = DATA_WIDTH;

  // Port codes; PORT_IDLE is decoded by no peripheral.
  localparam logic [PORT_WIDTH-1:0] PORT_IDLE         = 8'h00;
  localparam logic [PORT_WIDTH-1:0] PORT_ADDED_DATA   = 8'h01;
  localparam logic [PORT_WIDTH-1:0] PORT_ADD_DATA     = 8'h02;
  localparam logic [PORT_WIDTH-1:0] PORT_ADD_RESULT   = 8'h03;
  localparam logic [PORT_WIDTH-1:0] PORT_ADD_CARRY    = 8'h04;
  localparam logic [PORT_WIDTH-1:0] PORT_MINUSED_DATA = 8'h05;
  localparam logic [PORT_WIDTH-1:0] PORT_MINUS_DATA   = 8'h06;
  localparam logic [PORT_WIDTH-1:0] PORT_MINUS_RESULT = 8'h07;
  localparam logic [PORT_WIDTH-1:0] PORT_MINUS_CARRY  = 8'h08;

  // FSM state encoding.
  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_WR_A   = 3'd1;
  localparam logic [STATE_W-1:0] ST_WR_B   = 3'd2;
  localparam logic [STATE_W-1:0] ST_RD_REQ = 3'd3;
  localparam logic [STATE_W-1:0] ST_RD_CAP = 3'd4;
  localparam logic [STATE_W-1:0] ST_CR_REQ = 3'd5;
  localparam logic [STATE_W-1:0] ST_CR_CAP = 3'd6;
  localparam logic [STATE_W-1:0] ST_DONE   = 3'd7;

endpackage

// File: rtl/port_code_sel.sv
// port_code_sel: combinational map of (FSM state, op) to the bus port code.
// Ports: state (master FSM state), op (0 add / 1 sub), port (code for o_port).
// Any state that is not actively addressing a peripheral yields IDLE_CODE.
module port_code_sel #(
  parameter int                    PORT_WIDTH = port_master_pkg::PORT_WIDTH,
  parameter logic [PORT_WIDTH-1:0] IDLE_CODE  = PORT_WIDTH'(port_master_pkg::PORT_IDLE)
) (
  input  logic [port_master_pkg::STATE_W-1:0] state,
  input  logic                                op,
  output logic [PORT_WIDTH-1:0]               port
);
  import port_master_pkg::*;

  always_comb begin
    port = IDLE_CODE;
    case (state)
      ST_WR_A:   port = op ? PORT_WIDTH'(PORT_MINUSED_DATA) : PORT_WIDTH'(PORT_ADDED_DATA);
      ST_WR_B:   port = op ? PORT_WIDTH'(PORT_MINUS_DATA)   : PORT_WIDTH'(PORT_ADD_DATA);
      ST_RD_REQ: port = op ? PORT_WIDTH'(PORT_MINUS_RESULT) : PORT_WIDTH'(PORT_ADD_RESULT);
      ST_CR_REQ: port = op ? PORT_WIDTH'(PORT_MINUS_CARRY)  : PORT_WIDTH'(PORT_ADD_CARRY);
      default:   port = IDLE_CODE;
    endcase
  end

endmodule

// File: rtl/port_master.sv
// port_master: initiator that runs add/sub requests on a port-mapped peripheral.
// Ports: req_* (valid/ready request: op, a, b), rsp_* (valid/ready response:
// data, carry), o_port/o_data (bus drive), i_data (registered peripheral read).
// Optional macro PORT_MASTER_CARRY_EN adds a carry read (latency 7 instead of 5).
module port_master #(
  parameter int                    DATA_WIDTH = port_master_pkg::DATA_WIDTH,
  parameter int                    PORT_WIDTH = port_master_pkg::PORT_WIDTH,
  parameter logic [PORT_WIDTH-1:0] PORT_IDLE  = PORT_WIDTH'(port_master_pkg::PORT_IDLE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_op,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_carry,
  output logic [PORT_WIDTH-1:0] o_port,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic [DATA_WIDTH-1:0] i_data
);
  import port_master_pkg::*;

  logic [STATE_W-1:0]    state_q, state_d;
  logic                  op_q, op_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
`ifdef PORT_MASTER_CARRY_EN
  logic                  rsp_carry_q, rsp_carry_d;
`endif

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    rsp_data_d = rsp_data_q;
`ifdef PORT_MASTER_CARRY_EN
    rsp_carry_d = rsp_carry_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          a_d     = req_a;
          b_d     = req_b;
          state_d = ST_WR_A;
        end
      end
      ST_WR_A:   state_d = ST_WR_B;
      ST_WR_B:   state_d = ST_RD_REQ;
      ST_RD_REQ: state_d = ST_RD_CAP;
      ST_RD_CAP: begin
        // Peripheral registers its read data, so the result arrives the
        // cycle after the result port was addressed.
        rsp_data_d = i_data;
`ifdef PORT_MASTER_CARRY_EN
        state_d    = ST_CR_REQ;
`else
        state_d    = ST_DONE;
`endif
      end
`ifdef PORT_MASTER_CARRY_EN
      ST_CR_REQ: state_d = ST_CR_CAP;
      ST_CR_CAP: begin
        rsp_carry_d = i_data[0];
        state_d     = ST_DONE;
      end
`endif
      ST_DONE: begin
        // Always pass through IDLE so a new request is never taken here.
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_data_q <= '0;
`ifdef PORT_MASTER_CARRY_EN
      rsp_carry_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rsp_data_q <= rsp_data_d;
`ifdef PORT_MASTER_CARRY_EN
      rsp_carry_q <= rsp_carry_d;
`endif
    end
  end

  // Bus drive depends only on the state register and latched operands.
  always_comb begin
    o_data = '0;
    case (state_q)
      ST_WR_A: o_data = a_q;
      ST_WR_B: o_data = b_q;
      default: o_data = '0;
    endcase
  end

  port_code_sel #(
    .PORT_WIDTH (PORT_WIDTH),
    .IDLE_CODE  (PORT_IDLE)
  ) u_port_code_sel (
    .state (state_q),
    .op    (op_q),
    .port  (o_port)
  );

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_DONE);
  assign rsp_data  = rsp_data_q;
`ifdef PORT_MASTER_CARRY_EN
  assign rsp_carry = rsp_carry_q;
`else
  assign rsp_carry = 1'b0;
`endif

endmodule

// File: tb/tb_port_master.sv
// Bench for port_master: table vectors, corner sequences and random ops
// checked against an arithmetic reference model and a peripheral model.
module tb_port_master;
  import port_master_pkg::*;

`ifdef PORT_MASTER_CARRY_EN
  localparam bit CARRY_EN = 1'b1;
`else
  localparam bit CARRY_EN = 1'b0;
`endif
  localparam int EXP_LAT    = CARRY_EN ? 7 : 5;
  localparam int EXP_PERIOD = CARRY_EN ? 8 : 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_op = 1'b0;
  logic [7:0] req_a = 8'h00;
  logic [7:0] req_b = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_carry;
  logic [7:0] o_port;
  logic [7:0] o_data;
  logic [7:0] i_data = 8'h00;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  port_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry),
    .o_port(o_port), .o_data(o_data), .i_data(i_data)
  );

  // Peripheral model: operand registers written from the bus, registered reads.
  logic [7:0] per_a = 8'h00, per_b = 8'h00;
  always @(posedge clk) begin
    if (o_port == PORT_ADDED_DATA || o_port == PORT_MINUSED_DATA) per_a <= o_data;
    if (o_port == PORT_ADD_DATA   || o_port == PORT_MINUS_DATA)   per_b <= o_data;
    if (o_port == PORT_ADD_RESULT)        i_data <= per_a + per_b;
    else if (o_port == PORT_MINUS_RESULT) i_data <= per_a - per_b;
    else if (o_port == PORT_ADD_CARRY)    i_data <= {7'b0, (9'(per_a) + 9'(per_b)) > 9'd255};
    else if (o_port == PORT_MINUS_CARRY)  i_data <= {7'b0, per_a < per_b};
    else                                  i_data <= 8'h00;
  end

  // Bus monitor: log every addressed (port, data) pair while enabled.
  logic        log_en = 1'b0;
  logic [15:0] port_log[$];
  always @(negedge clk)
    if (log_en && o_port != PORT_IDLE) port_log.push_back({o_port, o_data});

  // Reference model: {carry/borrow, result} from plain arithmetic.
  function automatic logic [8:0] ref_op(input logic op, input logic [7:0] a, input logic [7:0] b);
    int r;
    if (op) begin
      r = int'(a) - int'(b);
      return {r < 0, 8'(r)};
    end
    r = int'(a) + int'(b);
    return {r > 255, 8'(r)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  // One full transaction; hold = cycles rsp_ready stays low once rsp_valid is seen.
  task automatic run_op(input logic op, input logic [7:0] a, input logic [7:0] b,
                        input int hold, output logic [7:0] d, output logic c, output int lat);
    int  n;
    bit  found;
    bit  stable;
    @(negedge clk);
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1; rsp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) chk("req_ready_timeout", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    // Scramble the inputs: the DUT must work from its latched copies.
    req_valid = 1'b0; req_op = 1'($urandom); req_a = 8'($urandom); req_b = 8'($urandom);
    n = 0; found = 1'b0;
    while (!found && n < 40) begin
      @(negedge clk); n++;
      if (rsp_valid) found = 1'b1;
    end
    if (!found) chk("rsp_valid_timeout", 32'(rsp_valid), 32'd1);
    lat = found ? n : -1;
    d = rsp_data; c = rsp_carry;
    if (hold > 0) begin
      stable = 1'b1;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        if (!rsp_valid || rsp_data !== d || rsp_carry !== c || req_ready) stable = 1'b0;
      end
      chk("hold_stable", 32'(stable), 32'd1);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic       op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_d;
    logic       exp_c;
  } vec_t;

  vec_t vecs[6];

  initial begin : main
    logic [7:0] d;
    logic       c;
    int         lat;
    logic [8:0] m;
    logic [15:0] exp_log[$];
    bit         ok;

    vecs[0] = '{1'b0, 8'h05, 8'h03, 8'h08, 1'b0};
    vecs[1] = '{1'b1, 8'h05, 8'h03, 8'h02, 1'b0};
    vecs[2] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[3] = '{1'b1, 8'h03, 8'h05, 8'hFE, 1'b1};
    vecs[4] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1};
    vecs[5] = '{1'b1, 8'h00, 8'hFF, 8'h01, 1'b1};

    // Reset state.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data",  32'(rsp_data),  32'd0);
    chk("rst_rsp_carry", 32'(rsp_carry), 32'd0);
    chk("rst_o_port",    32'(o_port),    32'(PORT_IDLE));
    chk("rst_o_data",    32'(o_data),    32'd0);

    // Table vectors: result, carry, latency and bus sequence.
    for (int i = 0; i < 6; i++) begin
      port_log.delete();
      log_en = 1'b1;
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, d, c, lat);
      log_en = 1'b0;
      chk("vec_data", 32'(d), 32'(vecs[i].exp_d));
      chk("vec_carry", 32'(c), 32'(CARRY_EN ? vecs[i].exp_c : 1'b0));
      chk("vec_latency", 32'(lat), 32'(EXP_LAT));
      exp_log.delete();
      exp_log.push_back({vecs[i].op ? PORT_MINUSED_DATA : PORT_ADDED_DATA, vecs[i].a});
      exp_log.push_back({vecs[i].op ? PORT_MINUS_DATA   : PORT_ADD_DATA,   vecs[i].b});
      exp_log.push_back({vecs[i].op ? PORT_MINUS_RESULT : PORT_ADD_RESULT, 8'h00});
      if (CARRY_EN) exp_log.push_back({vecs[i].op ? PORT_MINUS_CARRY : PORT_ADD_CARRY, 8'h00});
      chk("vec_bus_len", 32'(port_log.size()), 32'(exp_log.size()));
      for (int k = 0; k < exp_log.size() && k < port_log.size(); k++)
        chk("vec_bus_entry", 32'(port_log[k]), 32'(exp_log[k]));
    end

    // Backpressure: 10 cycles with rsp_ready low and a second request waiting.
    @(negedge clk);
    req_op = 1'b0; req_a = 8'h11; req_b = 8'h22; req_valid = 1'b1; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_a = 8'h01; req_b = 8'h01;
    ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      if (rsp_valid) ok = 1'b1;
    end
    chk("bp_first_valid", 32'(ok), 32'd1);
    ok = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data !== 8'h33 || req_ready || o_port !== PORT_IDLE) ok = 1'b0;
    end
    chk("bp_hold", 32'(ok), 32'd1);
    chk("bp_data", 32'(rsp_data), 32'h33);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_idle_ready", 32'(req_ready), 32'd1);
    chk("bp_idle_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("bp_second_accept", 32'(o_port), 32'(PORT_ADDED_DATA));
    ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      if (rsp_valid) ok = 1'b1;
    end
    chk("bp_second_data", 32'(rsp_data), 32'h02);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;

    // Reset asserted while the second operand is on the bus.
    @(negedge clk);
    req_op = 1'b0; req_a = 8'h44; req_b = 8'h55; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_wr_b", 32'(o_port), 32'(PORT_ADD_DATA));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_port", 32'(o_port), 32'(PORT_IDLE));
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    chk("rst_mid_valid", 32'(rsp_valid), 32'd0);
    ok = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (rsp_valid || o_port !== PORT_IDLE) ok = 1'b0;
    end
    chk("rst_mid_no_rsp", 32'(ok), 32'd1);
    run_op(1'b0, 8'h10, 8'h20, 0, d, c, lat);
    chk("rst_fresh_data", 32'(d), 32'h30);

    // Back-to-back: req_valid and rsp_ready held high for 4 ops.
    begin : b2b
      logic       b_op[4];
      logic [7:0] b_a[4], b_b[4];
      logic [7:0] expq[$];
      int idx, done, last_acc;
      bit acc, hs;
      for (int i = 0; i < 4; i++) begin
        b_op[i] = 1'($urandom); b_a[i] = 8'($urandom); b_b[i] = 8'($urandom);
      end
      @(negedge clk);
      idx = 0; done = 0; last_acc = -1;
      req_op = b_op[0]; req_a = b_a[0]; req_b = b_b[0];
      req_valid = 1'b1; rsp_ready = 1'b1;
      for (int cyc = 0; cyc < 80 && done < 4; cyc++) begin
        acc = req_valid && req_ready;
        hs  = rsp_valid && rsp_ready;
        if (hs) begin
          if (expq.size() > 0) chk("b2b_data", 32'(rsp_data), 32'(expq.pop_front()));
          else chk("b2b_unexpected_rsp", 32'd1, 32'd0);
          done++;
        end
        if (acc) begin
          m = ref_op(b_op[idx], b_a[idx], b_b[idx]);
          expq.push_back(m[7:0]);
          if (last_acc >= 0) chk("b2b_period", 32'(cyc - last_acc), 32'(EXP_PERIOD));
          last_acc = cyc;
          idx++;
        end
        @(posedge clk); #1;
        if (acc) begin
          if (idx < 4) begin req_op = b_op[idx]; req_a = b_a[idx]; req_b = b_b[idx]; end
          else req_valid = 1'b0;
        end
        @(negedge clk);
      end
      chk("b2b_count", 32'(done), 32'd4);
      req_valid = 1'b0; rsp_ready = 1'b0;
    end

    // Random operations with random response backpressure.
    for (int i = 0; i < 40; i++) begin
      logic       r_op;
      logic [7:0] r_a, r_b;
      r_op = 1'($urandom); r_a = 8'($urandom); r_b = 8'($urandom);
      m = ref_op(r_op, r_a, r_b);
      run_op(r_op, r_a, r_b, $urandom_range(0, 3), d, c, lat);
      chk("rand_data", 32'(d), 32'(m[7:0]));
      chk("rand_carry", 32'(c), 32'(CARRY_EN ? m[8] : 1'b0));
      chk("rand_latency", 32'(lat), 32'(EXP_LAT));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d", passed, total);
    $fatal(1);
  end

endmodule
